// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller and its flag register file.
// Holds the branch condition encodings, the controller state encoding and a
// helper that says whether a condition needs the ALU flags at all.
package branch_ctrl_pkg;

  localparam logic [3:0] CondEqual          = 4'd0;
  localparam logic [3:0] CondLess           = 4'd1;
  localparam logic [3:0] CondGreater        = 4'd2;
  localparam logic [3:0] CondGreaterOrEqual = 4'd3;
  localparam logic [3:0] CondAlways         = 4'd4;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StEval,
    StResolve,
    StFlush
  } state_e;

  // True for the four conditions that are decided by flag_rf.
  function automatic logic cond_uses_flags(input logic [3:0] cond);
    return (cond == CondEqual) || (cond == CondLess) ||
           (cond == CondGreater) || (cond == CondGreaterOrEqual);
  endfunction

endpackage

// File: rtl/flag_rf.sv
// Flag register file: evaluates a branch condition against z/v/n and
// registers the result.
//   clk  : clock
//   cond : condition code
//   z/v/n: zero, overflow, negative flags
//   out  : registered condition result (no reset; sampled only when valid)
module flag_rf
  import branch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] cond,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       out
);

  logic w_eval;

  always_comb begin
    w_eval = 1'b0;
    case (cond)
      CondEqual:          w_eval = z;
      CondLess:           w_eval = n ^ v;
      CondGreater:        w_eval = ~z & ~(n ^ v);
      CondGreaterOrEqual: w_eval = ~(n ^ v);
      default:            w_eval = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    out <= w_eval;
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: accepts one conditional branch at a time, waits for
// in-flight flag writers, evaluates the condition through flag_rf and issues
// a one-cycle redirect plus a FLUSH_CYCLES-long flush on a taken branch.
//   clk, rst                    : clock, async active-high reset
//   br_valid/br_cond/br_target  : branch from decode; br_ready accepts it
//   flag_busy                   : older flag-setting instruction in flight
//   flag_we, z, v, n            : ALU flag write
//   stall                       : hold upstream stages
//   resolved/taken              : one-cycle decision pulse and outcome
//   redirect/redirect_pc        : one-cycle PC load
//   flush                       : squash younger instructions
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W         = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic [3:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic            br_ready,
  input  logic            flag_busy,
  input  logic            flag_we,
  input  logic            z,
  input  logic            v,
  input  logic            n,
  output logic            stall,
  output logic            resolved,
  output logic            taken,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush
);

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

  state_e          r_state, w_state_next;
  logic [2:0]      r_hold;     // {z,v,n}
  logic [2:0]      r_snap;     // {z,v,n} frozen for flag_rf
  logic [3:0]      r_cond;
  logic [PC_W-1:0] r_target;
  logic [3:0]      r_cnt;
  logic [2:0]      w_flags_now;
  logic            w_accept;
  logic            w_rf_out;
  logic            w_outcome;

  assign w_accept    = br_valid && (r_state == StIdle);
  // Same-cycle flag write bypasses the hold register.
  assign w_flags_now = flag_we ? {z, v, n} : r_hold;
  // Forced outcomes never look at flag_rf.
  assign w_outcome   = (r_cond == CondAlways) ? 1'b1 :
                       cond_uses_flags(r_cond) ? w_rf_out : 1'b0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (br_valid) begin
          if (!cond_uses_flags(br_cond)) w_state_next = StResolve;
          else if (flag_busy)            w_state_next = StWait;
          else                           w_state_next = StEval;
        end
      end
      StWait:    if (!flag_busy) w_state_next = StEval;
      StEval:    w_state_next = StResolve;
      StResolve: w_state_next = (w_outcome && (FLUSH_CYCLES > 1)) ? StFlush : StIdle;
      StFlush:   if (r_cnt == 4'd1) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold   <= '0;
      r_snap   <= '0;
      r_cond   <= '0;
      r_target <= '0;
      r_cnt    <= '0;
    end else begin
      if (flag_we) r_hold <= {z, v, n};
      if (w_accept) begin
        r_cond   <= br_cond;
        r_target <= br_target;
      end
      if ((w_state_next == StEval) && (r_state != StEval)) r_snap <= w_flags_now;
      if (r_state == StResolve)    r_cnt <= FlushLoad;
      else if (r_state == StFlush) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Output logic
  always_comb begin
    br_ready    = 1'b0;
    stall       = 1'b1;
    resolved    = 1'b0;
    taken       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    flush       = 1'b0;
    unique case (r_state)
      StIdle: begin
        br_ready = 1'b1;
        stall    = br_valid;
      end
      StResolve: begin
        resolved = 1'b1;
        taken    = w_outcome;
        redirect = w_outcome;
        flush    = w_outcome;
        if (w_outcome) redirect_pc = r_target;
      end
      StFlush: flush = 1'b1;
      default: ;
    endcase
  end

  flag_rf rf_flag (
    .clk  (clk),
    .cond (r_cond),
    .z    (r_snap[2]),
    .v    (r_snap[1]),
    .n    (r_snap[0]),
    .out  (w_rf_out)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized
// branches checked against a flag/timing model derived from condition rules.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  localparam int unsigned PC_W  = 16;
  localparam int unsigned FLUSH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            br_valid;
  logic [3:0]      br_cond;
  logic [PC_W-1:0] br_target;
  logic            br_ready;
  logic            flag_busy, flag_we, z, v, n;
  logic            stall, resolved, taken, redirect, flush;
  logic [PC_W-1:0] redirect_pc;

  branch_ctrl #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH)) dut (
    .clk         (clk),
    .rst         (rst),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_target   (br_target),
    .br_ready    (br_ready),
    .flag_busy   (flag_busy),
    .flag_we     (flag_we),
    .z           (z),
    .v           (v),
    .n           (n),
    .stall       (stall),
    .resolved    (resolved),
    .taken       (taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observations of one run, indexed from the accept cycle (cycle 0).
  int         cyc, res_cnt, res_cyc, flush_cnt, idle_cyc, stall_gap, redir_cnt;
  logic       tk_s;
  logic [15:0] pc_s;
  int         res_q[$];
  logic [15:0] pc_q[$];

  logic [2:0] m_flags;   // model of architectural {z,v,n}
  logic [2:0] exp_snap;  // model flags the branch should be decided on

  // Condition rules stated as signed-compare meaning of the flags.
  function automatic logic ref_taken(input logic [3:0] c, input logic [2:0] f);
    logic fz, fv, fn, lt;
    fz = f[2]; fv = f[1]; fn = f[0];
    lt = (fn != fv);
    case (c)
      CondEqual:          return fz;
      CondLess:           return lt;
      CondGreater:        return !fz && !lt;
      CondGreaterOrEqual: return !lt;
      CondAlways:         return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic bit ref_forced(input logic [3:0] c);
    return !(c inside {CondEqual, CondLess, CondGreater, CondGreaterOrEqual});
  endfunction

  task automatic begin_obs();
    cyc = 0; res_cnt = 0; res_cyc = -1; flush_cnt = 0; idle_cyc = -1;
    stall_gap = 0; redir_cnt = 0; tk_s = 1'b0; pc_s = '0;
    res_q.delete(); pc_q.delete();
  endtask

  // Sample one cycle at the falling edge, then move to just after the next rise.
  task automatic step();
    @(negedge clk);
    if (resolved) begin res_cnt++; res_cyc = cyc; tk_s = taken; res_q.push_back(cyc); end
    if (redirect) begin redir_cnt++; pc_s = redirect_pc; pc_q.push_back(redirect_pc); end
    if (flush) flush_cnt++;
    if (cyc > 0 && idle_cyc < 0 && br_ready) idle_cyc = cyc;
    if (idle_cyc < 0 && !stall) stall_gap++;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic set_flags(input logic we, input logic [2:0] f);
    flag_we = we; z = f[2]; v = f[1]; n = f[0];
    if (we) m_flags = f;
  endtask

  // One branch: busy for cycles 0..w-1, optional random flag traffic and one
  // directed flag write at cycle sw_cyc. Runs until br_ready returns.
  task automatic run_one(input logic [3:0] c, input logic [15:0] tgt, input int w,
                         input bit rnd, input int sw_cyc, input logic [2:0] sw_f);
    begin_obs();
    br_cond = c; br_target = tgt;
    for (int k = 0; k < 40 && idle_cyc < 0; k++) begin
      br_valid  = (k == 0);
      flag_busy = (k < w);
      if (k == sw_cyc)  set_flags(1'b1, sw_f);
      else if (rnd)     set_flags(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      else              set_flags(1'b0, 3'b000);
      if (k == w) exp_snap = m_flags;
      step();
    end
    br_valid = 1'b0; flag_busy = 1'b0; flag_we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({br_ready, stall, resolved, taken, redirect, flush, redirect_pc} !== {1'b1, 5'b0, 16'h0}) begin
      n_errors++;
      $display("FAIL reset_initial: got ready/stall/res/tk/redir/flush/pc=%b%b%b%b%b%b/%h required 100000/0000",
               br_ready, stall, resolved, taken, redirect, flush, redirect_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({br_ready, stall, resolved, taken, redirect, flush, redirect_pc} !== {1'b1, 5'b0, 16'h0}) begin
      n_errors++;
      $display("FAIL reset_held: got ready/stall/res/tk/redir/flush/pc=%b%b%b%b%b%b/%h required 100000/0000",
               br_ready, stall, resolved, taken, redirect, flush, redirect_pc);
    end
    @(negedge clk) rst = 1'b0;
    m_flags = 3'b000;
    @(posedge clk); #1;
  endtask

  task automatic test_flags_written();
    logic exp_tk;
    set_flags(1'b1, 3'b100);
    @(posedge clk); #1;
    run_one(CondEqual, 16'h0040, 0, 1'b0, -1, 3'b000);
    exp_tk = ref_taken(CondEqual, exp_snap);
    n_checks++;
    if (res_cnt !== 1 || res_cyc !== 2) begin
      n_errors++;
      $display("FAIL written_resolve: got count=%0d cycle=%0d required count=1 cycle=2", res_cnt, res_cyc);
    end
    n_checks++;
    if (tk_s !== exp_tk) begin
      n_errors++; $display("FAIL written_taken: got %b required %b", tk_s, exp_tk);
    end
    n_checks++;
    if (redir_cnt !== 1 || pc_s !== 16'h0040) begin
      n_errors++;
      $display("FAIL written_redirect: got count=%0d pc=%h required count=1 pc=0040", redir_cnt, pc_s);
    end
    n_checks++;
    if (flush_cnt !== FLUSH || idle_cyc !== 2 + FLUSH) begin
      n_errors++;
      $display("FAIL written_flush: got flush=%0d ready_at=%0d required flush=%0d ready_at=%0d",
               flush_cnt, idle_cyc, FLUSH, 2 + FLUSH);
    end
  endtask

  task automatic test_pending_flags();
    logic exp_tk;
    set_flags(1'b1, 3'b000);
    @(posedge clk); #1;
    run_one(CondLess, 16'h0100, 3, 1'b0, 3, 3'b011);
    exp_tk = ref_taken(CondLess, exp_snap);
    n_checks++;
    if (res_cnt !== 1 || res_cyc !== 5 || tk_s !== exp_tk) begin
      n_errors++;
      $display("FAIL pending_resolve: got count=%0d cycle=%0d taken=%b required 1/5/%b",
               res_cnt, res_cyc, tk_s, exp_tk);
    end
    n_checks++;
    if (redir_cnt !== 0 || flush_cnt !== 0 || idle_cyc !== 6) begin
      n_errors++;
      $display("FAIL pending_no_redirect: got redir=%0d flush=%0d ready_at=%0d required 0/0/6",
               redir_cnt, flush_cnt, idle_cyc);
    end
    n_checks++;
    if (stall_gap !== 0) begin
      n_errors++; $display("FAIL pending_stall: got %0d stall-low cycles required 0", stall_gap);
    end
  endtask

  task automatic test_zero_wait();
    logic exp_tk;
    set_flags(1'b1, 3'b100);
    @(posedge clk); #1;
    // n=1 written during RESOLVE must not affect this branch.
    run_one(CondGreaterOrEqual, 16'h0abc, 0, 1'b0, 2, 3'b001);
    exp_tk = ref_taken(CondGreaterOrEqual, exp_snap);
    n_checks++;
    if (res_cyc !== 2 || tk_s !== exp_tk || pc_s !== 16'h0abc) begin
      n_errors++;
      $display("FAIL zero_wait: got cycle=%0d taken=%b pc=%h required 2/%b/0abc",
               res_cyc, tk_s, pc_s, exp_tk);
    end
    // The RESOLVE-cycle write must have reached the hold flags.
    run_one(CondLess, 16'h0abe, 0, 1'b0, -1, 3'b000);
    exp_tk = ref_taken(CondLess, exp_snap);
    n_checks++;
    if (res_cyc !== 2 || tk_s !== exp_tk) begin
      n_errors++;
      $display("FAIL zero_wait_hold: got cycle=%0d taken=%b required 2/%b", res_cyc, tk_s, exp_tk);
    end
  endtask

  task automatic test_forced();
    run_one(CondAlways, 16'h2000, 2, 1'b1, -1, 3'b000);
    n_checks++;
    if (res_cyc !== 1 || tk_s !== 1'b1 || redir_cnt !== 1 || pc_s !== 16'h2000 ||
        flush_cnt !== FLUSH || idle_cyc !== 1 + FLUSH) begin
      n_errors++;
      $display("FAIL forced_always: got cycle=%0d taken=%b redir=%0d pc=%h flush=%0d ready_at=%0d",
               res_cyc, tk_s, redir_cnt, pc_s, flush_cnt, idle_cyc);
    end
    set_flags(1'b1, 3'b100);
    @(posedge clk); #1;
    run_one(4'hF, 16'h3000, 0, 1'b0, -1, 3'b000);
    n_checks++;
    if (res_cnt !== 1 || res_cyc !== 1 || tk_s !== 1'b0 || redir_cnt !== 0 ||
        flush_cnt !== 0 || idle_cyc !== 2) begin
      n_errors++;
      $display("FAIL forced_undef: got count=%0d cycle=%0d taken=%b redir=%0d flush=%0d ready_at=%0d",
               res_cnt, res_cyc, tk_s, redir_cnt, flush_cnt, idle_cyc);
    end
  endtask

  task automatic test_reset_mid_flush();
    set_flags(1'b1, 3'b100);
    @(posedge clk); #1;
    flag_we = 1'b0;
    begin_obs();
    br_cond = CondEqual; br_target = 16'h4444; br_valid = 1'b1;
    step();
    br_valid = 1'b0;
    step();
    step();
    rst = 1'b1;  // cycle 3: inside the flush window
    #1;
    n_checks++;
    if (flush !== 1'b0 || stall !== 1'b0 || br_ready !== 1'b1 || redirect !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_flush: got flush=%b stall=%b ready=%b redirect=%b required 0/0/1/0",
               flush, stall, br_ready, redirect);
    end
    @(negedge clk) rst = 1'b0;
    m_flags = 3'b000;
    @(posedge clk); #1;
    run_one(CondGreater, 16'h1234, 1, 1'b0, -1, 3'b000);
    n_checks++;
    if (res_cnt !== 1 || res_cyc !== 3 || tk_s !== ref_taken(CondGreater, exp_snap) ||
        pc_s !== 16'h1234 || flush_cnt !== FLUSH || idle_cyc !== 3 + FLUSH) begin
      n_errors++;
      $display("FAIL after_reset: got count=%0d cycle=%0d taken=%b pc=%h flush=%0d ready_at=%0d",
               res_cnt, res_cyc, tk_s, pc_s, flush_cnt, idle_cyc);
    end
  endtask

  task automatic test_back_to_back();
    set_flags(1'b1, 3'b100);
    @(posedge clk); #1;
    flag_we = 1'b0;
    begin_obs();
    for (int k = 0; k < 12; k++) begin
      br_valid  = (k == 0) || (idle_cyc < 0);
      br_cond   = (k == 0) ? CondAlways : CondEqual;
      br_target = (k == 0) ? 16'h0500 : 16'h0600;
      step();
    end
    br_valid = 1'b0;
    n_checks++;
    if (idle_cyc !== 1 + FLUSH) begin
      n_errors++; $display("FAIL b2b_accept: got ready_at=%0d required %0d", idle_cyc, 1 + FLUSH);
    end
    n_checks++;
    if (res_q.size() !== 2 || pc_q.size() !== 2) begin
      n_errors++;
      $display("FAIL b2b_count: got resolved=%0d redirects=%0d required 2/2", res_q.size(), pc_q.size());
    end else if (res_q[0] !== 1 || res_q[1] !== 3 + FLUSH || pc_q[0] !== 16'h0500 || pc_q[1] !== 16'h0600) begin
      n_errors++;
      $display("FAIL b2b_order: got cycles=%0d,%0d pcs=%h,%h required 1,%0d 0500,0600",
               res_q[0], res_q[1], pc_q[0], pc_q[1], 3 + FLUSH);
    end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [15:0] tgt;
    int          w, sel, exp_res, exp_idle;
    logic        exp_tk;
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 6);
      c   = (sel <= 4) ? 4'(sel) : (sel == 5) ? 4'hF : 4'($urandom_range(5, 14));
      tgt = 16'($urandom);
      w   = $urandom_range(0, 3);
      run_one(c, tgt, w, 1'b1, -1, 3'b000);
      exp_tk   = ref_taken(c, exp_snap);
      exp_res  = ref_forced(c) ? 1 : w + 2;
      exp_idle = exp_res + (exp_tk ? FLUSH : 1);
      n_checks++;
      if (res_cnt !== 1 || res_cyc !== exp_res || tk_s !== exp_tk) begin
        n_errors++;
        $display("FAIL rand%0d_resolve cond=%h wait=%0d: got count=%0d cycle=%0d taken=%b required 1/%0d/%b",
                 i, c, w, res_cnt, res_cyc, tk_s, exp_res, exp_tk);
      end
      n_checks++;
      if (redir_cnt !== (exp_tk ? 1 : 0) || (exp_tk && pc_s !== tgt) ||
          flush_cnt !== (exp_tk ? FLUSH : 0) || idle_cyc !== exp_idle || stall_gap !== 0) begin
        n_errors++;
        $display("FAIL rand%0d_effects cond=%h: got redir=%0d pc=%h flush=%0d ready_at=%0d gaps=%0d required taken=%b pc=%h ready_at=%0d",
                 i, c, redir_cnt, pc_s, flush_cnt, idle_cyc, stall_gap, exp_tk, tgt, exp_idle);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_cond = '0; br_target = '0;
    flag_busy = 1'b0; flag_we = 1'b0; z = 1'b0; v = 1'b0; n = 1'b0;
    m_flags = 3'b000; exp_snap = 3'b000;
    test_reset();
    test_flags_written();
    test_pending_flags();
    test_zero_wait();
    test_forced();
    test_reset_mid_flush();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequences conditional branch resolution around the flag register file (flag_rf). It accepts one branch at a time from decode and stalls while an older flag-setting instruction is in flight. It then presents a flag snapshot and the branch condition to a flag_rf instance and samples its registered output. On a taken branch it issues a one-cycle PC redirect and a multi-cycle pipeline flush.

Parameters:
PC_W, 16, width of branch target and redirect PC
FLUSH_CYCLES, 2, cycles flush stays high per taken branch (legal range 1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
br_valid  in  1  decode presents a branch
br_cond  in  4  condition code (`EQUAL, `LESS, `GREATER, `GREATER_OR_EQUAL, `ALWAYS)
br_target  in  PC_W  branch target address
br_ready  out  1  controller can accept a branch
flag_busy  in  1  an older flag-setting instruction has not yet written flags
flag_we  in  1  ALU writes z/v/n this cycle
z  in  1  ALU zero flag
v  in  1  ALU overflow flag
n  in  1  ALU negative flag
stall  out  1  hold upstream stages
resolved  out  1  one-cycle pulse, branch decided
taken  out  1  branch outcome, valid only while resolved=1
redirect  out  1  one-cycle pulse, load redirect_pc into PC
redirect_pc  out  PC_W  target, valid while redirect=1
flush  out  1  squash younger instructions

Behaviour:
- Reset: async. State goes to IDLE. Hold flags, snapshot, latched cond/target and flush counter all clear to 0. Reset values: br_ready=1, stall=0, resolved=0, taken=0, redirect=0, redirect_pc=0, flush=0. Asserting reset mid-operation drops all pulses at once and abandons the branch.
- Hold flag register {z,v,n} updates on any cycle with flag_we=1, in every state.
- Accept: br_valid & br_ready in IDLE latches br_cond and br_target. br_ready=1 only in IDLE.
- stall=1 in WAIT, EVAL, RESOLVE and FLUSH. It is also 1 in IDLE on the cycle a branch is accepted. stall is combinational from br_valid in IDLE.
- IDLE -> on accept: cond=`ALWAYS goes to RESOLVE (taken forced to 1). Undefined cond goes to RESOLVE (taken forced to 0). Otherwise flag_busy=1 goes to WAIT; flag_busy=0 goes to EVAL.
- WAIT -> EVAL on the first cycle with flag_busy=0.
- On the edge entering EVAL, snapshot <= flag_we ? {z,v,n} : hold. This bypass means a same-cycle flag write is used.
- EVAL: flag_rf is driven with the latched cond and the snapshot. flag_rf registers out at the end of EVAL. flag_rf inputs stay frozen on the snapshot through RESOLVE, so a later flag_we cannot disturb the branch.
- RESOLVE (1 cycle): resolved=1 and taken=flag_rf.out, or the forced value.
  - Taken: redirect=1, redirect_pc=latched target, flush=1, counter loaded with FLUSH_CYCLES-1. Next state is FLUSH, or IDLE if FLUSH_CYCLES=1.
  - Not taken: no redirect, no flush, next state IDLE.
- FLUSH: flush=1 and the counter decrements. Returns to IDLE after the cycle in which counter=1. Total flush-high cycles equal FLUSH_CYCLES.
- Condition semantics (implemented in flag_rf; controller relies on them):
  - EQUAL = z
  - LESS = n^v
  - GREATER = ~z & ~(n^v)
  - GREATER_OR_EQUAL = ~(n^v)
- Latency with no wait: accept at cycle 0, EVAL at 1, resolved/redirect at 2, back in IDLE at 2+FLUSH_CYCLES.
- flag_rf out is never sampled outside RESOLVE; its unreset X value before the first edge is harmless.
- br_valid while not ready is ignored. Decode must hold the branch until accepted.

Decomposition:
- Condition encodings live in the shared defines file alongside the existing `EQUAL/`LESS/`GREATER/`GREATER_OR_EQUAL. This block adds `ALWAYS there.
- State encodings (IDLE, WAIT, EVAL, RESOLVE, FLUSH) are local defines in the same shared file.
- One sub-module: flag_rf, instantiated unchanged as rf_flag with ports (clk, cond, z, v, n, out).

Test Plan:
- Flags already written: flag_we with z=1, then br_valid with cond=`EQUAL, target=16'h0040, flag_busy=0.
  -> resolved/taken/redirect=1 at cycle 2, redirect_pc=16'h0040, flush high exactly 2 cycles, br_ready back at cycle 4.
- Pending flags: cond=`LESS with flag_busy=1 for 3 cycles, then flag_we with n=1, v=1 in the cycle busy drops.
  -> bypassed snapshot is used, taken=0, no redirect, no flush, stall high throughout the wait.
- Zero wait: cond=`GREATER_OR_EQUAL, z=1, n=v=0, flag_busy=0.
  -> taken=1 at cycle 2. Then a flag_we with n=1 during RESOLVE does not change taken.
- Forced outcomes: cond=`ALWAYS -> resolved/redirect at cycle 1. Undefined cond 4'hF -> taken=0 at cycle 1, no flag_rf dependency.
- Reset mid-FLUSH: rst pulse during the first flush cycle.
  -> flush=0 and stall=0 immediately, br_ready=1, and the next branch resolves normally.
- Back-to-back: second br_valid held high during FLUSH.
  -> not accepted until IDLE; accepted on the first IDLE cycle; no lost or duplicated resolved pulses.
